// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the two-client physical-memory arbiter.
// The round-robin option is selected by defining PMEM_ARB_RR_EN (see pmem_arbiter_control).
package pmem_arbiter_pkg;

    localparam int PMEM_ADDR_W = 16;
    localparam int PMEM_LINE_W = 128;

    typedef logic [PMEM_ADDR_W-1:0] lc3b_word;
    typedef logic [PMEM_LINE_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } pmem_arb_state_t;

    typedef enum logic {
        CLIENT_I = 1'b0,
        CLIENT_D = 1'b1
    } pmem_client_t;

    // Winner among the requesters; with rr_en a tie goes to whoever was not served last.
    function automatic pmem_client_t pick_client(
        input logic         req_i,
        input logic         req_d,
        input pmem_client_t last,
        input logic         rr_en
    );
        pmem_client_t winner;
        if (req_i && req_d) begin
            winner = (rr_en && (last == CLIENT_D)) ? CLIENT_I : CLIENT_D;
        end else if (req_i) begin
            winner = CLIENT_I;
        end else begin
            winner = CLIENT_D;
        end
        return winner;
    endfunction

endpackage

// File: rtl/pmem_arbiter_control.sv
// Arbiter FSM: grant decode, last-grant tracking and the DONE turnaround cycle.
// Defining PMEM_ARB_RR_EN turns simultaneous-request resolution into round-robin.
module pmem_arbiter_control
    import pmem_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_i_i,
    input  logic            req_d_i,
    input  logic            pmem_resp_i,
    output pmem_arb_state_t state_o,
    output logic            load_o,
    output pmem_client_t    load_client_o,
    output logic            grant_done_o,
    output pmem_client_t    last_grant_o
);

`ifdef PMEM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    pmem_arb_state_t state_q, state_d;
    pmem_client_t    last_grant_q, last_grant_d;
    pmem_client_t    winner;

    assign winner = pick_client(req_i_i, req_d_i, last_grant_q, RR_EN);

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        load_o        = 1'b0;
        load_client_o = CLIENT_D;
        grant_done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i_i || req_d_i) begin
                    load_o        = 1'b1;
                    load_client_o = winner;
                    state_d       = (winner == CLIENT_D) ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I: begin
                if (pmem_resp_i) begin
                    grant_done_o = 1'b1;
                    last_grant_d = CLIENT_I;
                    state_d      = DONE;
                end
            end
            GRANT_D: begin
                if (pmem_resp_i) begin
                    grant_done_o = 1'b1;
                    last_grant_d = CLIENT_D;
                    state_d      = DONE;
                end
            end
            // Turnaround lets the served client drop its request before we look again.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= CLIENT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign state_o      = state_q;
    assign last_grant_o = last_grant_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Serialises icache/dcache line requests onto one pmem port with latched address/data.
// Optional round-robin tie-break: define PMEM_ARB_RR_EN.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    pmem_arb_state_t state;
    logic            load;
    pmem_client_t    load_client;
    logic            grant_done;
    pmem_client_t    last_grant;

    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    pmem_arbiter_control u_control (
        .clk           (clk),
        .reset         (reset),
        .req_i_i       (i_pmem_read | i_pmem_write),
        .req_d_i       (d_pmem_read | d_pmem_write),
        .pmem_resp_i   (pmem_resp),
        .state_o       (state),
        .load_o        (load),
        .load_client_o (load_client),
        .grant_done_o  (grant_done),
        .last_grant_o  (last_grant)
    );

    // Read wins over an illegal read+write so pmem never sees both strobes.
    always_comb begin
        read_d  = read_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (load) begin
            if (load_client == CLIENT_D) begin
                read_d  = d_pmem_read;
                write_d = d_pmem_write & ~d_pmem_read;
                addr_d  = d_pmem_address;
                wdata_d = d_pmem_wdata;
            end else begin
                read_d  = i_pmem_read;
                write_d = i_pmem_write & ~i_pmem_read;
                addr_d  = i_pmem_address;
                wdata_d = i_pmem_wdata;
            end
        end else if (grant_done) begin
            read_d  = 1'b0;
            write_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign pmem_read    = read_q;
    assign pmem_write   = write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp  = (state == GRANT_I) && pmem_resp;
    assign d_pmem_resp  = (state == GRANT_D) && pmem_resp;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    // Protocol checks; last_grant is referenced here so it stays observable in the fixed-priority build.
    a_i_rw_exclusive: assert property (@(posedge clk) disable iff (!reset)
        !(i_pmem_read && i_pmem_write));
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!reset)
        !(d_pmem_read && d_pmem_write));
    a_resp_in_grant: assert property (@(posedge clk) disable iff (!reset)
        pmem_resp |-> ((state == GRANT_I) || (state == GRANT_D)));
    a_last_grant_known: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown(last_grant));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus randomized rounds vs. a grant-order model.
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_pmem_read = 1'b0, i_pmem_write = 1'b0;
    logic [ADDR_W-1:0] i_pmem_address = '0;
    logic [LINE_W-1:0] i_pmem_wdata = '0;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read = 1'b0, d_pmem_write = 1'b0;
    logic [ADDR_W-1:0] d_pmem_address = '0;
    logic [LINE_W-1:0] d_pmem_wdata = '0;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read, pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;

    int total = 0;
    int bad = 0;

    // Reference model state: who was served last, and what each client asked for.
    pmem_client_t      last_grant_m = CLIENT_I;
    logic              req_wr_m   [2];
    logic [ADDR_W-1:0] req_addr_m [2];
    lc3b_line          req_wdata_m[2];

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_write   (i_pmem_write),
        .i_pmem_address (i_pmem_address),
        .i_pmem_wdata   (i_pmem_wdata),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    task automatic chk(input string tag, input lc3b_line obs, input lc3b_line exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic lc3b_line rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Fixed D priority on a tie unless round-robin is built in; a lone requester always wins.
    function automatic pmem_client_t model_pick(input bit ri, input bit rd);
        if (ri && rd) begin
`ifdef PMEM_ARB_RR_EN
            return (last_grant_m == CLIENT_I) ? CLIENT_D : CLIENT_I;
`else
            return CLIENT_D;
`endif
        end
        return ri ? CLIENT_I : CLIENT_D;
    endfunction

    task automatic drive_client(input pmem_client_t c, input bit rd, input bit wr,
                                input logic [ADDR_W-1:0] a, input lc3b_line wd);
        if (c == CLIENT_I) begin
            i_pmem_read = rd; i_pmem_write = wr; i_pmem_address = a; i_pmem_wdata = wd;
        end else begin
            d_pmem_read = rd; d_pmem_write = wr; d_pmem_address = a; d_pmem_wdata = wd;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd"}, lc3b_line'(pmem_read), '0);
        chk({tag, "_wr"}, lc3b_line'(pmem_write), '0);
        chk({tag, "_iresp"}, lc3b_line'(i_pmem_resp), '0);
        chk({tag, "_dresp"}, lc3b_line'(d_pmem_resp), '0);
    endtask

    // Starts in IDLE with c's request already driven; ends in DONE with c's request dropped.
    task automatic serve(input pmem_client_t c, input int lat, input bit mutate, input lc3b_line rdv);
        int ci;
        string n;
        ci = int'(c);
        n = (c == CLIENT_I) ? "i" : "d";
        @(posedge clk); #1;
        chk({n, "_strobe_rd"}, lc3b_line'(pmem_read), lc3b_line'(!req_wr_m[ci]));
        chk({n, "_strobe_wr"}, lc3b_line'(pmem_write), lc3b_line'(req_wr_m[ci]));
        chk({n, "_addr"}, lc3b_line'(pmem_address), lc3b_line'(req_addr_m[ci]));
        chk({n, "_wdata"}, pmem_wdata, req_wdata_m[ci]);
        for (int k = 1; k < lat; k++) begin
            if (mutate && k == 1)
                drive_client(c, !req_wr_m[ci], req_wr_m[ci], req_addr_m[ci] ^ 16'h1000, ~req_wdata_m[ci]);
            pmem_rdata = rand_line();
            @(posedge clk); #1;
            chk({n, "_addr_hold"}, lc3b_line'(pmem_address), lc3b_line'(req_addr_m[ci]));
            chk({n, "_wdata_hold"}, pmem_wdata, req_wdata_m[ci]);
            chk({n, "_rd_hold"}, lc3b_line'(pmem_read), lc3b_line'(!req_wr_m[ci]));
            chk({n, "_early_resp"}, lc3b_line'(i_pmem_resp | d_pmem_resp), '0);
        end
        pmem_rdata = rdv;
        pmem_resp  = 1'b1;
        #1;
        chk({n, "_iresp"}, lc3b_line'(i_pmem_resp), lc3b_line'(c == CLIENT_I));
        chk({n, "_dresp"}, lc3b_line'(d_pmem_resp), lc3b_line'(c == CLIENT_D));
        chk({n, "_i_rdata"}, i_pmem_rdata, rdv);
        chk({n, "_d_rdata"}, d_pmem_rdata, rdv);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        drive_client(c, 1'b0, 1'b0, req_addr_m[ci], req_wdata_m[ci]);
        #1;
        chk_idle_outputs({n, "_done"});
    endtask

    task automatic do_round(input bit ri, input bit rd,
                            input bit iwr, input logic [ADDR_W-1:0] ia, input lc3b_line iwd,
                            input bit dwr, input logic [ADDR_W-1:0] da, input lc3b_line dwd,
                            input int lat, input bit mutate, input lc3b_line rdv);
        pmem_client_t first, second;
        req_wr_m[0] = iwr; req_addr_m[0] = ia; req_wdata_m[0] = iwd;
        req_wr_m[1] = dwr; req_addr_m[1] = da; req_wdata_m[1] = dwd;
        drive_client(CLIENT_I, ri && !iwr, ri && iwr, ia, iwd);
        drive_client(CLIENT_D, rd && !dwr, rd && dwr, da, dwd);
        first = model_pick(ri, rd);
        $display("round: req_i=%0d req_d=%0d expect first=%s", ri, rd, (first == CLIENT_D) ? "D" : "I");
        serve(first, lat, mutate, rdv);
        last_grant_m = first;
        if (ri && rd) begin
            second = (first == CLIENT_D) ? CLIENT_I : CLIENT_D;
            @(posedge clk); #1;
            chk_idle_outputs("turnaround_idle");
            serve(second, lat, 1'b0, ~rdv);
            last_grant_m = second;
        end
        @(posedge clk); #1;
        chk_idle_outputs("round_end_idle");
    endtask

    initial begin
        bit ri, rd;
        int kind;

        // Reset held with both clients requesting: everything stays quiet.
        drive_client(CLIENT_I, 1'b1, 1'b0, 16'h0111, '0);
        drive_client(CLIENT_D, 1'b1, 1'b0, 16'h0222, '0);
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_addr", lc3b_line'(pmem_address), '0);
        chk("reset_wdata", pmem_wdata, '0);
        reset = 1'b1;
        do_round(1, 1, 0, 16'h0111, '0, 0, 16'h0222, '0, 2, 0, rand_line());

        // Single icache fill.
        do_round(1, 0, 0, 16'h1230, rand_line(), 0, 16'h0000, '0, 5, 0,
                 {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF});

        // Simultaneous i read / d write, then address-stability with a mutated d request.
        do_round(1, 1, 0, 16'h0040, rand_line(), 1, 16'h8000, {16{8'hA5}}, 3, 0, rand_line());
        do_round(0, 1, 0, 16'h0000, '0, 1, 16'h8000, {16{8'hA5}}, 4, 1, rand_line());

        // Two consecutive tie rounds exercise the tie-break order.
        do_round(1, 1, 0, 16'h0300, rand_line(), 0, 16'h0400, rand_line(), 2, 0, rand_line());
        do_round(1, 1, 1, 16'h0500, rand_line(), 1, 16'h0600, rand_line(), 1, 0, rand_line());

        // Reset in the middle of a dcache grant aborts it.
        drive_client(CLIENT_D, 1'b0, 1'b1, 16'h4444, rand_line());
        @(posedge clk); #1;
        chk("abort_granted", lc3b_line'(pmem_write), 1);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_wr_drop", lc3b_line'(pmem_write), '0);
        chk("abort_rd_drop", lc3b_line'(pmem_read), '0);
        pmem_resp = 1'b1;
        #1;
        chk("abort_dresp", lc3b_line'(d_pmem_resp), '0);
        pmem_resp = 1'b0;
        drive_client(CLIENT_D, 1'b0, 1'b0, 16'h4444, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        last_grant_m = CLIENT_I;
        @(posedge clk); #1;
        chk_idle_outputs("abort_after");

        // Randomized rounds: the next round's 1-cycle grant latency also confirms IDLE.
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 2);
            ri = (kind != 1);
            rd = (kind != 0);
            do_round(ri, rd,
                     1'($urandom_range(0, 1)), 16'($urandom), rand_line(),
                     1'($urandom_range(0, 1)), 16'($urandom), rand_line(),
                     $urandom_range(1, 6), 1'($urandom_range(0, 1)), rand_line());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
